// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the RISC-V datapath: fetch/decode/execute/
// memory/writeback with a shared-memory handshake, illegal-opcode trap and retire counter.
module multicycle_control_fsm #(
  parameter int ALUOP_W         = 2,
  parameter int CNT_W           = 32,
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               adr_src,
  output logic               ir_write,
  output logic               pc_write,
  output logic               reg_write,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         result_src,
  output logic               illegal_instr,
  output logic [3:0]         state_o,
  output logic [CNT_W-1:0]   instret
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_EXEC_I   = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FN  = ALUOP_W'(2);

  logic [3:0]         state_reg, state_next;
  logic [CNT_W-1:0]   instret_reg;
  logic               opcode_legal;
  logic               retire;

  logic               mem_req_next, mem_we_next, adr_src_next, ir_write_next;
  logic               pc_write_next, reg_write_next, illegal_next;
  logic [1:0]         alu_src_a_next, alu_src_b_next, result_src_next;
  logic [ALUOP_W-1:0] alu_op_next;

  always_comb begin
    opcode_legal = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_R) ||
                   (opcode == OP_I)  || (opcode == OP_BR) || (opcode == OP_JAL);
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXEC_R;
          OP_I:         state_next = S_EXEC_I;
          OP_BR:        state_next = S_BRANCH;
          OP_JAL:       state_next = S_JAL;
          default:      state_next = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
        endcase
      end
      // Opcode is held in IR, so it still selects the load/store path here.
      S_MEMADR: begin
        if (opcode == OP_LW)      state_next = S_MEMREAD;
        else if (opcode == OP_SW) state_next = S_MEMWRITE;
        else                      state_next = S_FETCH;
      end
      S_MEMREAD:  state_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXEC_R:   state_next = S_ALUWB;
      S_EXEC_I:   state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req_next    = 1'b0;
    mem_we_next     = 1'b0;
    adr_src_next    = 1'b0;
    ir_write_next   = 1'b0;
    pc_write_next   = 1'b0;
    reg_write_next  = 1'b0;
    illegal_next    = 1'b0;
    alu_src_a_next  = 2'b00;
    alu_src_b_next  = 2'b00;
    result_src_next = 2'b00;
    alu_op_next     = ALU_ADD;
    case (state_reg)
      S_FETCH: begin
        mem_req_next    = 1'b1;
        alu_src_b_next  = 2'b10;
        result_src_next = 2'b10;
        ir_write_next   = mem_ready;
        pc_write_next   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a_next = 2'b01;
        alu_src_b_next = 2'b01;
        illegal_next   = ~opcode_legal;
      end
      S_MEMADR: begin
        alu_src_a_next = 2'b10;
        alu_src_b_next = 2'b01;
      end
      S_MEMREAD: begin
        mem_req_next = 1'b1;
        adr_src_next = 1'b1;
      end
      S_MEMWB: begin
        result_src_next = 2'b01;
        reg_write_next  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_next = 1'b1;
        mem_we_next  = 1'b1;
        adr_src_next = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a_next = 2'b10;
        alu_op_next    = ALU_FN;
      end
      S_EXEC_I: begin
        alu_src_a_next = 2'b10;
        alu_src_b_next = 2'b01;
        alu_op_next    = ALU_FN;
      end
      S_ALUWB: reg_write_next = 1'b1;
      S_BRANCH: begin
        alu_src_a_next = 2'b10;
        alu_op_next    = ALU_SUB;
        pc_write_next  = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
        illegal_next   = (funct3 != 3'b000) && (funct3 != 3'b001);
      end
      // Target was computed into ALUOut during DECODE; ALUWB then links OldPC+4.
      S_JAL: begin
        alu_src_a_next = 2'b01;
        alu_src_b_next = 2'b10;
        pc_write_next  = 1'b1;
      end
      S_TRAP:  illegal_next = 1'b1;
      default: ;
    endcase
  end

  // Reset blanks every output in the reset cycle, abandoning any memory request.
  always_comb begin
    mem_req       = mem_req_next   & ~rst;
    mem_we        = mem_we_next    & ~rst;
    adr_src       = adr_src_next   & ~rst;
    ir_write      = ir_write_next  & ~rst;
    pc_write      = pc_write_next  & ~rst;
    reg_write     = reg_write_next & ~rst;
    illegal_instr = illegal_next   & ~rst;
    alu_src_a     = rst ? 2'b00 : alu_src_a_next;
    alu_src_b     = rst ? 2'b00 : alu_src_b_next;
    result_src    = rst ? 2'b00 : result_src_next;
    alu_op        = rst ? ALU_ADD : alu_op_next;
    state_o       = rst ? S_FETCH : state_reg;
    instret       = rst ? '0 : instret_reg;
  end

  always_comb begin
    retire = (state_reg == S_MEMWB) || (state_reg == S_ALUWB) ||
             (state_reg == S_BRANCH) || ((state_reg == S_MEMWRITE) && mem_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_FETCH;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) instret_reg <= instret_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench: per-cycle vector table for instruction sequences, then
// hand-written reset-in-handshake and illegal-opcode sequences on both trap modes.
module tb_multicycle_control_fsm;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        zero;
  logic        mem_ready;

  logic        mem_req_a, mem_we_a, adr_src_a, ir_write_a, pc_write_a, reg_write_a, ill_a;
  logic [1:0]  asa_a, asb_a, aop_a, rs_a;
  logic [3:0]  st_a;
  logic [31:0] ir_a;
  logic        mem_req_b, mem_we_b, adr_src_b, ir_write_b, pc_write_b, reg_write_b, ill_b;
  logic [1:0]  asa_b, asb_b, aop_b, rs_b;
  logic [3:0]  st_b;
  logic [31:0] ir_b;

  logic [14:0] ctl_a, ctl_b;
  assign ctl_a = {mem_req_a, mem_we_a, adr_src_a, ir_write_a, pc_write_a, reg_write_a,
                  asa_a, asb_a, aop_a, rs_a, ill_a};
  assign ctl_b = {mem_req_b, mem_we_b, adr_src_b, ir_write_b, pc_write_b, reg_write_b,
                  asa_b, asb_b, aop_b, rs_b, ill_b};

  multicycle_control_fsm #(.ALUOP_W(2), .CNT_W(32), .TRAP_ON_ILLEGAL(1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req_a), .mem_we(mem_we_a), .adr_src(adr_src_a),
    .ir_write(ir_write_a), .pc_write(pc_write_a), .reg_write(reg_write_a),
    .alu_src_a(asa_a), .alu_src_b(asb_a), .alu_op(aop_a), .result_src(rs_a),
    .illegal_instr(ill_a), .state_o(st_a), .instret(ir_a)
  );

  multicycle_control_fsm #(.ALUOP_W(2), .CNT_W(32), .TRAP_ON_ILLEGAL(0)) dut_nop (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req_b), .mem_we(mem_we_b), .adr_src(adr_src_b),
    .ir_write(ir_write_b), .pc_write(pc_write_b), .reg_write(reg_write_b),
    .alu_src_a(asa_b), .alu_src_b(asb_b), .alu_op(aop_b), .result_src(rs_b),
    .illegal_instr(ill_b), .state_o(st_b), .instret(ir_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [14:0] ctl;
    logic [31:0] ir;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011, BR = 7'b1100011, JL = 7'b1101111, ILL = 7'b1111111;

  function automatic logic [14:0] c(input logic mr, we, as, irw, pcw, rw,
                                    input logic [1:0] a, b, op, rs, input logic ill);
    return {mr, we, as, irw, pcw, rw, a, b, op, rs, ill};
  endfunction

  function automatic vec_t mkv(input logic r, input logic [6:0] op, input logic [2:0] f3,
                               input logic z, rdy, input logic [3:0] st,
                               input logic [14:0] ctl, input logic [31:0] ir);
    vec_t v;
    v.rst = r; v.op = op; v.f3 = f3; v.z = z; v.rdy = rdy; v.st = st; v.ctl = ctl; v.ir = ir;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [6:0] op, input logic [2:0] f3,
                       input logic z, input logic rdy);
    @(posedge clk);
    #1;
    rst = r; opcode = op; funct3 = f3; zero = z; mem_ready = rdy;
    #3;
  endtask

  logic [14:0] K0, K_GO, K_WAIT, K_DEC, K_DECI, K_MA, K_MR, K_MWB, K_MW;
  logic [14:0] K_EXR, K_EXI, K_WB, K_BRT, K_BRN, K_BRI, K_JAL, K_TRAP;

  initial begin
    rst = 1'b1; opcode = R; funct3 = 3'b000; zero = 1'b0; mem_ready = 1'b1;

    K0     = '0;
    K_GO   = c(1,0,0,1,1,0, 2'b00,2'b10,2'b00,2'b10, 0);
    K_WAIT = c(1,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 0);
    K_DEC  = c(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0);
    K_DECI = c(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 1);
    K_MA   = c(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0);
    K_MR   = c(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0);
    K_MWB  = c(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b01, 0);
    K_MW   = c(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0);
    K_EXR  = c(0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 0);
    K_EXI  = c(0,0,0,0,0,0, 2'b10,2'b01,2'b10,2'b00, 0);
    K_WB   = c(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 0);
    K_BRT  = c(0,0,0,0,1,0, 2'b10,2'b00,2'b01,2'b00, 0);
    K_BRN  = c(0,0,0,0,0,0, 2'b10,2'b00,2'b01,2'b00, 0);
    K_BRI  = c(0,0,0,0,0,0, 2'b10,2'b00,2'b01,2'b00, 1);
    K_JAL  = c(0,0,0,0,1,0, 2'b01,2'b10,2'b00,2'b00, 0);
    K_TRAP = c(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1);

    // reset, then add / addi
    tbl.push_back(mkv(1, R, 0, 0, 1, 0, K0, 0));
    tbl.push_back(mkv(1, R, 0, 0, 1, 0, K0, 0));
    tbl.push_back(mkv(0, R, 0, 0, 1, 0, K_GO, 0));
    tbl.push_back(mkv(0, R, 0, 0, 1, 1, K_DEC, 0));
    tbl.push_back(mkv(0, R, 0, 0, 1, 6, K_EXR, 0));
    tbl.push_back(mkv(0, R, 0, 0, 1, 8, K_WB, 0));
    tbl.push_back(mkv(0, I, 0, 0, 1, 0, K_GO, 1));
    tbl.push_back(mkv(0, I, 0, 0, 1, 1, K_DEC, 1));
    tbl.push_back(mkv(0, I, 0, 0, 1, 7, K_EXI, 1));
    tbl.push_back(mkv(0, I, 0, 0, 1, 8, K_WB, 1));
    // lw with three wait cycles in MEMREAD
    tbl.push_back(mkv(0, LW, 2, 0, 1, 0, K_GO, 2));
    tbl.push_back(mkv(0, LW, 2, 0, 1, 1, K_DEC, 2));
    tbl.push_back(mkv(0, LW, 2, 0, 1, 2, K_MA, 2));
    tbl.push_back(mkv(0, LW, 2, 0, 0, 3, K_MR, 2));
    tbl.push_back(mkv(0, LW, 2, 0, 0, 3, K_MR, 2));
    tbl.push_back(mkv(0, LW, 2, 0, 0, 3, K_MR, 2));
    tbl.push_back(mkv(0, LW, 2, 0, 1, 3, K_MR, 2));
    tbl.push_back(mkv(0, LW, 2, 0, 1, 4, K_MWB, 2));
    // beq taken, bne not taken, bad funct3
    tbl.push_back(mkv(0, BR, 0, 1, 1, 0, K_GO, 3));
    tbl.push_back(mkv(0, BR, 0, 1, 1, 1, K_DEC, 3));
    tbl.push_back(mkv(0, BR, 0, 1, 1, 9, K_BRT, 3));
    tbl.push_back(mkv(0, BR, 1, 1, 1, 0, K_GO, 4));
    tbl.push_back(mkv(0, BR, 1, 1, 1, 1, K_DEC, 4));
    tbl.push_back(mkv(0, BR, 1, 1, 1, 9, K_BRN, 4));
    tbl.push_back(mkv(0, BR, 2, 1, 1, 0, K_GO, 5));
    tbl.push_back(mkv(0, BR, 2, 1, 1, 1, K_DEC, 5));
    tbl.push_back(mkv(0, BR, 2, 1, 1, 9, K_BRI, 5));
    // jal, then a fetch wait cycle, then sw
    tbl.push_back(mkv(0, JL, 0, 0, 1, 0, K_GO, 6));
    tbl.push_back(mkv(0, JL, 0, 0, 1, 1, K_DEC, 6));
    tbl.push_back(mkv(0, JL, 0, 0, 1, 10, K_JAL, 6));
    tbl.push_back(mkv(0, JL, 0, 0, 1, 8, K_WB, 6));
    tbl.push_back(mkv(0, SW, 2, 0, 0, 0, K_WAIT, 7));
    tbl.push_back(mkv(0, SW, 2, 0, 1, 0, K_GO, 7));
    tbl.push_back(mkv(0, SW, 2, 0, 1, 1, K_DEC, 7));
    tbl.push_back(mkv(0, SW, 2, 0, 1, 2, K_MA, 7));
    tbl.push_back(mkv(0, SW, 2, 0, 1, 5, K_MW, 7));
    tbl.push_back(mkv(0, SW, 2, 0, 1, 0, K_GO, 8));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].op, tbl[i].f3, tbl[i].z, tbl[i].rdy);
      check("state", i, 32'(st_a), 32'(tbl[i].st));
      check("ctl", i, 32'(ctl_a), 32'(tbl[i].ctl));
      check("instret", i, ir_a, tbl[i].ir);
      check("nop_state", i, 32'(st_b), 32'(tbl[i].st));
      check("nop_ctl", i, 32'(ctl_b), 32'(tbl[i].ctl));
      check("nop_instret", i, ir_b, tbl[i].ir);
      $display("vec %0d: rst=%0b op=%07b f3=%0d rdy=%0b state=%0d ctl=%04h instret=%0d",
               i, tbl[i].rst, tbl[i].op, tbl[i].f3, tbl[i].rdy, st_a, ctl_a, ir_a);
    end

    // sw interrupted by reset while MEMWRITE waits on memory
    drive(0, SW, 2, 0, 1);
    check("sw_dec_state", 0, 32'(st_a), 1);
    drive(0, SW, 2, 0, 1);
    check("sw_ma_state", 0, 32'(st_a), 2);
    drive(0, SW, 2, 0, 0);
    check("sw_mw_we", 0, 32'(mem_we_a), 1);
    check("sw_mw_instret", 0, ir_a, 8);
    drive(1, SW, 2, 0, 0);
    check("sw_rst_we", 0, 32'(mem_we_a), 0);
    check("sw_rst_req", 0, 32'(mem_req_a), 0);
    check("sw_rst_ctl", 0, 32'(ctl_a), 32'(K0));
    drive(0, ILL, 0, 0, 1);
    check("sw_after_state", 0, 32'(st_a), 0);
    check("sw_after_instret", 0, ir_a, 0);
    check("sw_after_ctl", 0, 32'(ctl_a), 32'(K_GO));
    $display("seq sw-reset: state=%0d instret=%0d", st_a, ir_a);

    // illegal opcode: trapping instance vs NOP instance
    drive(0, ILL, 0, 0, 1);
    check("ill_dec_trap", 0, 32'(ctl_a), 32'(K_DECI));
    check("ill_dec_nop", 0, 32'(ctl_b), 32'(K_DECI));
    drive(0, ILL, 0, 0, 1);
    check("trap_state", 0, 32'(st_a), 11);
    check("trap_ctl", 0, 32'(ctl_a), 32'(K_TRAP));
    check("nop_back_state", 0, 32'(st_b), 0);
    check("nop_back_ill", 0, 32'(ill_b), 0);
    check("nop_back_instret", 0, ir_b, 0);
    drive(0, R, 0, 0, 1);
    check("trap_hold_state", 1, 32'(st_a), 11);
    check("trap_hold_ctl", 1, 32'(ctl_a), 32'(K_TRAP));
    drive(0, R, 0, 0, 1);
    check("trap_hold_state", 2, 32'(st_a), 11);
    drive(1, R, 0, 0, 1);
    check("trap_rst_ctl", 0, 32'(ctl_a), 32'(K0));
    drive(0, R, 0, 0, 1);
    check("trap_exit_state", 0, 32'(st_a), 0);
    check("trap_exit_instret", 0, ir_a, 0);
    check("trap_exit_ctl", 0, 32'(ctl_a), 32'(K_GO));
    $display("seq illegal: state=%0d instret=%0d", st_a, ir_a);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
